cfu_requant_issuer: RTL and testbench

- Initiator side of the CFU command/response interface; drives the two-step requantization command pair that the CFU responder executes.
- Accepts requant jobs (accumulator, multiplier, shift, offset) over valid/ready.
- Issues cmd #1 (high-mul), then cmd #2 (shift + offset), captures the final response, clamps it to the activation range and returns it over valid/ready.
- Sits between the accelerator's accumulator drain and the CFU port; replaces CPU-issued instruction pairs.

---
 rtl/cfu_pkg.sv | 23 ++
 rtl/cfu_requant_issuer_if.sv | 21 ++
 rtl/cfu_watchdog.sv | 22 ++
 rtl/cfu_requant_issuer.sv | 169 ++++++++++++++++
 tb/tb_cfu_requant_issuer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfu_pkg.sv
// cfu_pkg: shared CFU initiator types, constants and the activation clamp helper
package cfu_pkg;
    localparam int CFU_DATA_W = 32;
    localparam logic [6:0] CFU_FUNC_REQUANT = 7'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_RSP1,
        ST_CMD2,
        ST_RSP2,
        ST_OUT,
        ST_ERROR
    } cfu_state_e;

    function automatic logic signed [CFU_DATA_W-1:0] sat_clamp(
        input logic signed [CFU_DATA_W-1:0] value,
        input logic signed [CFU_DATA_W-1:0] lo,
        input logic signed [CFU_DATA_W-1:0] hi
    );
        return (value < lo) ? lo : (value > hi) ? hi : value;
    endfunction
endpackage

// File: rtl/cfu_requant_issuer_if.sv
// cfu_requant_issuer_if: CFU command/response bus between an initiator and the responder
interface cfu_requant_issuer_if;
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [9:0]                      cmd_payload_function_id;
    logic [cfu_pkg::CFU_DATA_W-1:0] cmd_payload_inputs_0;
    logic [cfu_pkg::CFU_DATA_W-1:0] cmd_payload_inputs_1;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [cfu_pkg::CFU_DATA_W-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_watchdog.sv
// cfu_watchdog: cycle counter that flags a stuck CFU handshake state
module cfu_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // restart on every state entry, count while the guarded state persists
    always_comb cnt_d = clear ? '0 : enable ? cnt_q + CW'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/cfu_requant_issuer.sv
// cfu_requant_issuer: issues the high-mul / shift+offset CFU command pair per requant job and clamps the result
module cfu_requant_issuer import cfu_pkg::*; #(
    parameter logic [9:0]        FUNC_ID        = {CFU_FUNC_REQUANT, 3'd0},
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter bit                CLAMP_EN       = 1'b1,
    parameter logic signed [31:0] ACT_MIN       = -32'sd128,
    parameter logic signed [31:0] ACT_MAX       = 32'sd127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [CFU_DATA_W-1:0]  job_acc,
    input  logic [CFU_DATA_W-1:0]  job_mult,
    input  logic [4:0]             job_shift,
    input  logic [CFU_DATA_W-1:0]  job_offset,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CFU_DATA_W-1:0]  res_data,
    cfu_requant_issuer_if.master   cfu,
    output logic                   busy,
    output logic                   error,
    output logic [15:0]            jobs_done
);
    cfu_state_e state_q, state_d;
    logic job_ready_q, job_ready_d;
    logic cmd_valid_q, cmd_valid_d;
    logic rsp_ready_q, rsp_ready_d;
    logic res_valid_q, res_valid_d;
    logic error_q, error_d;
    logic busy_q, busy_d;
    logic [15:0] jobs_done_q, jobs_done_d;
    logic [CFU_DATA_W-1:0] res_data_q, res_data_d;
    logic [CFU_DATA_W-1:0] in0_q, in0_d;
    logic [CFU_DATA_W-1:0] in1_q, in1_d;
    logic [CFU_DATA_W-1:0] mul_hi_q, mul_hi_d;
    logic [4:0] shift_q, shift_d;
    logic [CFU_DATA_W-1:0] offset_q, offset_d;
    logic wd_clear, wd_enable, wd_expired;
    logic unused_mul_hi;

    // mul_hi is kept only for debug visibility
    assign unused_mul_hi = ^mul_hi_q;

    assign job_ready = job_ready_q;
    assign res_valid = res_valid_q;
    assign res_data = res_data_q;
    assign busy = busy_q;
    assign error = error_q;
    assign jobs_done = jobs_done_q;
    assign cfu.cmd_valid = cmd_valid_q;
    assign cfu.rsp_ready = rsp_ready_q;
    assign cfu.cmd_payload_function_id = FUNC_ID;
    assign cfu.cmd_payload_inputs_0 = in0_q;
    assign cfu.cmd_payload_inputs_1 = in1_q;

    assign wd_enable = (state_q == ST_CMD1) || (state_q == ST_RSP1) || (state_q == ST_CMD2) || (state_q == ST_RSP2);
    assign wd_clear = state_d != state_q;

    cfu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk(clk),
        .reset(reset),
        .clear(wd_clear),
        .enable(wd_enable),
        .expired(wd_expired)
    );

    // next-state and registered-output logic; a stalled handshake traps in ERROR
    always_comb begin
        state_d = state_q;
        job_ready_d = job_ready_q;
        cmd_valid_d = cmd_valid_q;
        rsp_ready_d = rsp_ready_q;
        res_valid_d = res_valid_q;
        error_d = error_q;
        jobs_done_d = jobs_done_q;
        res_data_d = res_data_q;
        in0_d = in0_q;
        in1_d = in1_q;
        mul_hi_d = mul_hi_q;
        shift_d = shift_q;
        offset_d = offset_q;
        case (state_q)
            ST_IDLE: if (job_valid && job_ready_q) begin
                state_d = ST_CMD1;
                job_ready_d = 1'b0;
                cmd_valid_d = 1'b1;
                in0_d = job_acc;
                in1_d = job_mult;
                shift_d = job_shift;
                offset_d = job_offset;
            end
            ST_CMD1: if (cfu.cmd_ready) begin
                state_d = ST_RSP1;
                cmd_valid_d = 1'b0;
                rsp_ready_d = 1'b1;
            end
            ST_RSP1: if (cfu.rsp_valid) begin
                state_d = ST_CMD2;
                mul_hi_d = cfu.rsp_payload_outputs_0;
                rsp_ready_d = 1'b0;
                cmd_valid_d = 1'b1;
                in0_d = {{(CFU_DATA_W-5){1'b0}}, shift_q};
                in1_d = offset_q;
            end
            ST_CMD2: if (cfu.cmd_ready) begin
                state_d = ST_RSP2;
                cmd_valid_d = 1'b0;
                rsp_ready_d = 1'b1;
            end
            ST_RSP2: if (cfu.rsp_valid) begin
                state_d = ST_OUT;
                rsp_ready_d = 1'b0;
                res_valid_d = 1'b1;
                res_data_d = CLAMP_EN ? sat_clamp($signed(cfu.rsp_payload_outputs_0), ACT_MIN, ACT_MAX)
                                      : cfu.rsp_payload_outputs_0;
            end
            ST_OUT: if (res_ready) begin
                state_d = ST_IDLE;
                res_valid_d = 1'b0;
                job_ready_d = 1'b1;
                jobs_done_d = jobs_done_q + 16'd1;
            end
            default: ;
        endcase
        if (wd_expired && state_d == state_q) begin
            state_d = ST_ERROR;
            cmd_valid_d = 1'b0;
            rsp_ready_d = 1'b0;
            error_d = 1'b1;
        end
        busy_d = state_d != ST_IDLE;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            job_ready_q <= 1'b1;
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q <= 1'b0;
            jobs_done_q <= '0;
            res_data_q <= '0;
            in0_q <= '0;
            in1_q <= '0;
            mul_hi_q <= '0;
            shift_q <= '0;
            offset_q <= '0;
        end else begin
            state_q <= state_d;
            job_ready_q <= job_ready_d;
            cmd_valid_q <= cmd_valid_d;
            rsp_ready_q <= rsp_ready_d;
            res_valid_q <= res_valid_d;
            error_q <= error_d;
            busy_q <= busy_d;
            jobs_done_q <= jobs_done_d;
            res_data_q <= res_data_d;
            in0_q <= in0_d;
            in1_q <= in1_d;
            mul_hi_q <= mul_hi_d;
            shift_q <= shift_d;
            offset_q <= offset_d;
        end
    end
endmodule

// File: tb/tb_cfu_requant_issuer.sv
// tb_cfu_requant_issuer: directed test of the requant command-pair issuer against a behavioural CFU responder
module tb_cfu_requant_issuer;
    logic clk = 1'b0;
    logic reset;
    logic job_valid, job_ready, res_valid, res_ready, busy, error;
    logic [31:0] job_acc, job_mult, job_offset, res_data;
    logic [4:0] job_shift;
    logic [15:0] jobs_done;
    logic job_valid_nc, job_ready_nc, res_valid_nc, res_ready_nc, busy_nc, error_nc;
    logic [31:0] res_data_nc;
    logic [15:0] jobs_done_nc;
    int tests = 0;
    int fails = 0;
    int cmd_stall, rsp_lat;
    logic mute;

    cfu_requant_issuer_if bus();
    cfu_requant_issuer_if bus_nc();

    cfu_requant_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_acc(job_acc), .job_mult(job_mult),
        .job_shift(job_shift), .job_offset(job_offset),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .cfu(bus.master), .busy(busy), .error(error), .jobs_done(jobs_done)
    );

    cfu_requant_issuer #(.CLAMP_EN(1'b0)) dut_nc (
        .clk(clk), .reset(reset),
        .job_valid(job_valid_nc), .job_ready(job_ready_nc), .job_acc(job_acc), .job_mult(job_mult),
        .job_shift(job_shift), .job_offset(job_offset),
        .res_valid(res_valid_nc), .res_ready(res_ready_nc), .res_data(res_data_nc),
        .cfu(bus_nc.master), .busy(busy_nc), .error(error_nc), .jobs_done(jobs_done_nc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mulhi(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed(a) * $signed(b);
        return p[62:31];
    endfunction

    function automatic logic [31:0] step2(input logic [31:0] hi, input logic [31:0] sh, input logic [31:0] off);
        return ($signed(hi) >>> sh[4:0]) + $signed(off);
    endfunction

    // configurable responder: cmd_ready after cmd_stall cycles, rsp_valid rsp_lat cycles after the cmd handshake
    logic r_pend, r_phase;
    int r_cnt, r_scnt;
    logic [31:0] r_hi, r_res;
    assign bus.cmd_ready = !r_pend && (r_scnt >= cmd_stall);
    assign bus.rsp_valid = r_pend && (r_cnt == 0) && !mute;
    assign bus.rsp_payload_outputs_0 = r_res;
    always @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0; r_phase <= 1'b0; r_cnt <= 0; r_scnt <= 0; r_hi <= '0; r_res <= '0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                r_pend <= 1'b1;
                r_cnt <= rsp_lat - 1;
                r_scnt <= 0;
                r_phase <= !r_phase;
                if (!r_phase) r_hi <= mulhi(bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1);
                r_res <= r_phase ? step2(r_hi, bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1)
                                 : mulhi(bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1);
            end else if (bus.cmd_valid) r_scnt <= r_scnt + 1;
            if (bus.rsp_valid && bus.rsp_ready) r_pend <= 1'b0;
            else if (r_pend && r_cnt > 0) r_cnt <= r_cnt - 1;
        end
    end

    // fixed L=1 responder for the unclamped instance
    logic n_pend, n_phase;
    logic [31:0] n_hi, n_res;
    assign bus_nc.cmd_ready = !n_pend;
    assign bus_nc.rsp_valid = n_pend;
    assign bus_nc.rsp_payload_outputs_0 = n_res;
    always @(posedge clk) begin
        if (reset) begin
            n_pend <= 1'b0; n_phase <= 1'b0; n_hi <= '0; n_res <= '0;
        end else if (bus_nc.cmd_valid && bus_nc.cmd_ready) begin
            n_pend <= 1'b1;
            n_phase <= !n_phase;
            if (!n_phase) n_hi <= mulhi(bus_nc.cmd_payload_inputs_0, bus_nc.cmd_payload_inputs_1);
            n_res <= n_phase ? step2(n_hi, bus_nc.cmd_payload_inputs_0, bus_nc.cmd_payload_inputs_1)
                             : mulhi(bus_nc.cmd_payload_inputs_0, bus_nc.cmd_payload_inputs_1);
        end else if (bus_nc.rsp_valid && bus_nc.rsp_ready) n_pend <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] m, input logic [4:0] s, input logic [31:0] o);
        job_acc = a; job_mult = m; job_shift = s; job_offset = o; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] m, input logic [4:0] s,
                           input logic [31:0] o, input logic [31:0] exp, input logic [31:0] exp_hi);
        int n;
        accept(a, m, s, o);
        n = 1;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 5);
        check({tag, "_res"}, res_data, exp);
        check({tag, "_mulhi"}, dut.mul_hi_q, exp_hi);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_res_valid_drop"}, res_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen, early;
        reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0; job_valid_nc = 1'b0; res_ready_nc = 1'b0;
        job_acc = '0; job_mult = '0; job_shift = '0; job_offset = '0;
        mute = 1'b0; cmd_stall = 0; rsp_lat = 1;
        repeat (2) @(negedge clk);
        check("rst_job_ready", job_ready, 1);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_rsp_ready", bus.rsp_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_error", error, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_res_data", res_data, 0);
        check("rst_in0", bus.cmd_payload_inputs_0, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // basic job, cycle by cycle
        accept(1000, 32'h4000_0000, 2, -128);
        check("c1_valid", bus.cmd_valid, 1);
        check("c1_in0", bus.cmd_payload_inputs_0, 1000);
        check("c1_in1", bus.cmd_payload_inputs_1, 32'h4000_0000);
        check("func_id", {22'd0, bus.cmd_payload_function_id}, 0);
        check("c1_job_ready", job_ready, 0);
        check("c1_busy", busy, 1);
        @(negedge clk);
        check("r1_rsp_ready", bus.rsp_ready, 1);
        check("r1_cmd_valid", bus.cmd_valid, 0);
        @(negedge clk);
        check("c2_valid", bus.cmd_valid, 1);
        check("c2_in0", bus.cmd_payload_inputs_0, 2);
        check("c2_in1", bus.cmd_payload_inputs_1, -128);
        check("c2_mulhi", dut.mul_hi_q, 500);
        @(negedge clk);
        check("r2_rsp_ready", bus.rsp_ready, 1);
        check("r2_res_valid", res_valid, 0);
        @(negedge clk);
        check("out_res_valid", res_valid, 1);
        check("out_res_data", res_data, -3);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("j1_res_valid", res_valid, 0);
        check("j1_jobs_done", jobs_done, 1);
        check("j1_job_ready", job_ready, 1);

        // clamp boundaries and arithmetic floor
        run_job("clamp_hi", 100000, 32'h4000_0000, 0, 0, 127, 50000);
        run_job("floor", -7, 32'h4000_0000, 1, 0, -2, -4);
        run_job("clamp_lo", -200000, 32'h4000_0000, 1, 0, -128, -100000);
        check("jobs_done_4", jobs_done, 4);

        // unclamped instance passes the raw response
        job_acc = 100000; job_mult = 32'h4000_0000; job_shift = 0; job_offset = 0; job_valid_nc = 1'b1;
        @(negedge clk);
        job_valid_nc = 1'b0;
        repeat (4) @(negedge clk);
        check("nc_res_valid", res_valid_nc, 1);
        check("nc_res_data", res_data_nc, 50000);
        res_ready_nc = 1'b1;
        @(negedge clk);
        res_ready_nc = 1'b0;
        check("nc_jobs_done", jobs_done_nc, 1);

        // stalled responder and consumer; a second job stays offered
        cmd_stall = 3; rsp_lat = 5;
        accept(1000, 32'h4000_0000, 2, -128);
        job_valid = 1'b1;
        seen = 1'b0;
        n = 1;
        while (!res_valid && n < 100) begin
            if (bus.rsp_ready) seen = 1'b1;
            if (bus.cmd_valid) begin
                check("stall_in0", bus.cmd_payload_inputs_0, seen ? 32'd2 : 32'd1000);
                check("stall_in1", bus.cmd_payload_inputs_1, seen ? 32'hFFFF_FF80 : 32'h4000_0000);
            end
            check("stall_job_ready", job_ready, 0);
            @(negedge clk);
            n++;
        end
        check("stall_lat", n, 19);
        for (int i = 0; i < 6; i++) begin
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, -3);
            check("hold_job_ready", job_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("stall_res_valid", res_valid, 0);
        check("stall_job_ready_back", job_ready, 1);
        check("stall_jobs_done", jobs_done, 5);
        job_valid = 1'b0;
        @(negedge clk);
        check("stall_no_second", busy, 0);
        cmd_stall = 0; rsp_lat = 1;

        // watchdog: responder silent after cmd #1
        mute = 1'b1;
        accept(5, 32'h4000_0000, 0, 0);
        n = 0;
        while (!bus.rsp_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wd_rsp1_seen", bus.rsp_ready, 1);
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (error) early = 1'b1;
        end
        check("wd_not_early", early, 0);
        @(negedge clk);
        check("wd_error", error, 1);
        check("wd_cmd_valid", bus.cmd_valid, 0);
        check("wd_rsp_ready", bus.rsp_ready, 0);
        check("wd_res_valid", res_valid, 0);
        check("wd_job_ready", job_ready, 0);
        job_valid = 1'b1;
        repeat (3) @(negedge clk);
        job_valid = 1'b0;
        check("wd_ignore_job", bus.cmd_valid, 0);
        check("wd_sticky", error, 1);
        mute = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("wd_reset_error", error, 0);
        check("wd_reset_job_ready", job_ready, 1);
        check("wd_reset_jobs_done", jobs_done, 0);
        @(negedge clk);

        // reset while waiting in RSP2
        rsp_lat = 8;
        accept(1000, 32'h4000_0000, 2, -128);
        n = 0;
        while (!(bus.rsp_ready && bus.cmd_payload_inputs_0 == 32'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp2_reached", bus.rsp_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_cmd_valid", bus.cmd_valid, 0);
        check("mid_rst_rsp_ready", bus.rsp_ready, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_job_ready", job_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in0", bus.cmd_payload_inputs_0, 0);
        check("mid_rst_res_data", res_data, 0);
        rsp_lat = 1;
        @(negedge clk);
        run_job("after_rst", -7, 32'h4000_0000, 1, 0, -2, -4);
        check("after_rst_jobs_done", jobs_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
